// File: rtl/cheshire_spi_target_pkg.sv
// SPI target shared types: opcodes, FSM states, status byte layout.
// Imported by the SPI target top and its bench.
package cheshire_spi_target_pkg;

  localparam logic [7:0] SpiTgtCmdWrite  = 8'h02;
  localparam logic [7:0] SpiTgtCmdRead   = 8'h03;
  localparam logic [7:0] SpiTgtCmdStatus = 8'h05;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StDummy,
    StRdata,
    StStat,
    StIgnore
  } spi_tgt_state_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic       busy;
    logic       timeout;
    logic       bus_err;
  } spi_tgt_status_t;

endpackage

// File: rtl/cheshire_spi_target_if.sv
// Register-interface bundle between the SPI target and the reg demux.
// master: request side (valid/write/addr/wdata/wstrb); slave: response.
interface cheshire_spi_target_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 valid;
  logic                 write;
  logic [AddrWidth-1:0] addr;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 ready;
  logic [31:0]          rdata;
  logic                 error;

  modport master (
    output valid, write, addr, wdata, wstrb,
    input  ready, rdata, error
  );

  modport slave (
    input  valid, write, addr, wdata, wstrb,
    output ready, rdata, error
  );
endinterface

// File: rtl/cheshire_spi_target_sync.sv
// Input synchronizer plus sck/csb edge detect for the SPI target.
// Ports: raw sck/csb/sd in; sck_rise/sck_fall/csb_fall, synced csb/sd out.
module cheshire_spi_target_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic csb_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_fall_o,
  output logic csb_o,
  output logic sd_o
);

  localparam int unsigned L = SyncStages - 1;

  logic [L:0] sck_q, sck_d;
  logic [L:0] csb_q, csb_d;
  logic [L:0] sd_q, sd_d;
  logic       sck_prev_q, sck_prev_d;
  logic       csb_prev_q, csb_prev_d;

  always_comb begin
    sck_d      = {sck_q[L-1:0], sck_i};
    csb_d      = {csb_q[L-1:0], csb_i};
    sd_d       = {sd_q[L-1:0], sd_i};
    sck_prev_d = sck_q[L];
    csb_prev_d = csb_q[L];
  end

  // csb resets deasserted so a held-low csb reads as a fresh frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_q      <= '0;
      csb_q      <= '1;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      sck_q      <= sck_d;
      csb_q      <= csb_d;
      sd_q       <= sd_d;
      sck_prev_q <= sck_prev_d;
      csb_prev_q <= csb_prev_d;
    end
  end

  assign sck_rise_o = sck_q[L] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[L] & sck_prev_q;
  assign csb_fall_o = ~csb_q[L] & csb_prev_q;
  assign csb_o      = csb_q[L];
  assign sd_o       = sd_q[L];

endmodule

// File: rtl/cheshire_spi_target.sv
// Oversampled mode-0 SPI target issuing 32-bit register reads/writes.
// Ports: clk/rst, SPI sck/csb/sd in, sd/sd_en out, reg-bus master.
module cheshire_spi_target
  import cheshire_spi_target_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DummyBits  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spi_sck_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_sd_i,
  output logic                 spi_sd_o,
  output logic                 spi_sd_en_o,
  output logic                 reg_valid_o,
  output logic                 reg_write_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic [31:0]          reg_rdata_i,
  input  logic                 reg_error_i
);

  localparam int unsigned ShW = AddrWidth > 32 ? AddrWidth : 32;
  localparam int unsigned MaxBits = ShW > DummyBits ? ShW : DummyBits;
  localparam int unsigned CntW = $clog2(MaxBits);
  localparam logic [CntW-1:0] CmdLast  = CntW'(7);
  localparam logic [CntW-1:0] AddrLast = CntW'(AddrWidth - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(31);
  localparam logic [CntW-1:0] DumLast  = CntW'(DummyBits - 1);

  logic sck_rise, sck_fall, csb_fall, csb_s, sd_s;

  cheshire_spi_target_sync #(
    .SyncStages(SyncStages)
  ) i_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sck_i     (spi_sck_i),
    .csb_i     (spi_csb_i),
    .sd_i      (spi_sd_i),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .csb_fall_o(csb_fall),
    .csb_o     (csb_s),
    .sd_o      (sd_s)
  );

  spi_tgt_state_e       state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ShW-2:0]       shift_q, shift_d;
  logic [31:0]          out_q, out_d;
  logic                 sd_q, sd_d;
  logic                 sd_en_q, sd_en_d;
  logic                 valid_q, valid_d;
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rd_cmd_q, rd_cmd_d;
  logic                 rd_done_q, rd_done_d;
  logic                 loaded_q, loaded_d;
  logic                 stat_busy_q, stat_busy_d;
  logic                 timeout_q, timeout_d;
  logic                 bus_err_q, bus_err_d;

  logic [ShW-1:0]  sh_in;
  logic [7:0]      cmd;
  logic [CntW-1:0] cnt_inc;
  spi_tgt_status_t status;

  assign sh_in   = {shift_q, sd_s};
  assign cmd     = sh_in[7:0];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    status         = '0;
    status.busy    = valid_q;
    status.timeout = timeout_q;
    status.bus_err = bus_err_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_d       = out_q;
    sd_d        = sd_q;
    valid_d     = valid_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    rd_cmd_d    = rd_cmd_q;
    rd_done_d   = rd_done_q;
    loaded_d    = loaded_q;
    stat_busy_d = stat_busy_q;
    timeout_d   = timeout_q;
    bus_err_d   = bus_err_q;

    // Bus side runs regardless of csb: an issued request always retires.
    if (valid_q && reg_ready_i) begin
      valid_d = 1'b0;
      if (reg_error_i) bus_err_d = 1'b1;
      if (!write_q) begin
        rd_done_d = 1'b1;
        rdata_d   = reg_error_i ? '1 : reg_rdata_i;
      end
    end

    if (csb_s) begin
      state_d = StIdle;
      cnt_d   = '0;
      sd_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (csb_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            shift_d = sh_in[ShW-2:0];
            cnt_d   = cnt_inc;
            if (cnt_q == CmdLast) begin
              cnt_d = '0;
              unique case (1'b1)
                cmd == SpiTgtCmdStatus: begin
                  state_d     = StStat;
                  out_d       = {status, 24'b0};
                  sd_d        = status[7];
                  stat_busy_d = valid_q;
                end
                (cmd == SpiTgtCmdWrite || cmd == SpiTgtCmdRead)
                  && !valid_q: begin
                  state_d  = StAddr;
                  rd_cmd_d = (cmd == SpiTgtCmdRead);
                end
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            shift_d = sh_in[ShW-2:0];
            cnt_d   = cnt_inc;
            if (cnt_q == AddrLast) begin
              cnt_d  = '0;
              addr_d = sh_in[AddrWidth-1:0];
              if (rd_cmd_q) begin
                state_d   = StDummy;
                valid_d   = 1'b1;
                write_d   = 1'b0;
                wstrb_d   = 4'hF;
                rd_done_d = 1'b0;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StWdata: begin
          if (sck_rise) begin
            shift_d = sh_in[ShW-2:0];
            cnt_d   = cnt_inc;
            if (cnt_q == DataLast) begin
              cnt_d   = '0;
              state_d = StIgnore;
              wdata_d = sh_in[31:0];
              valid_d = 1'b1;
              write_d = 1'b1;
              wstrb_d = 4'hF;
            end
          end
        end
        StDummy: begin
          if (sck_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == DumLast) begin
              cnt_d    = '0;
              state_d  = StRdata;
              loaded_d = rd_done_q;
              out_d    = rd_done_q ? rdata_q : '1;
              sd_d     = rd_done_q ? rdata_q[31] : 1'b1;
            end
          end
        end
        StRdata: begin
          // First fall is the last chance for data; otherwise send all-ones.
          if (sck_fall) begin
            if (!loaded_q) begin
              loaded_d = 1'b1;
              if (rd_done_q) begin
                out_d = rdata_q;
                sd_d  = rdata_q[31];
              end else begin
                out_d     = '1;
                sd_d      = 1'b1;
                timeout_d = 1'b1;
              end
            end else begin
              sd_d = out_q[31];
            end
          end
          if (sck_rise) begin
            out_d = {out_q[30:0], 1'b0};
            cnt_d = cnt_inc;
            if (cnt_q == DataLast) begin
              cnt_d   = '0;
              state_d = StIgnore;
              sd_d    = 1'b0;
            end
          end
        end
        StStat: begin
          if (sck_fall) sd_d = out_q[31];
          if (sck_rise) begin
            out_d = {out_q[30:0], 1'b0};
            cnt_d = cnt_inc;
            if (cnt_q == CmdLast) begin
              cnt_d   = '0;
              state_d = StIgnore;
              sd_d    = 1'b0;
              // Flags of a still-outstanding request survive until it retires.
              if (!stat_busy_q) begin
                timeout_d = 1'b0;
                bus_err_d = 1'b0;
              end
            end
          end
        end
        StIgnore: sd_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end

    sd_en_d = (state_d == StRdata) || (state_d == StStat);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_q       <= '0;
      sd_q        <= 1'b0;
      sd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      rd_cmd_q    <= 1'b0;
      rd_done_q   <= 1'b0;
      loaded_q    <= 1'b0;
      stat_busy_q <= 1'b0;
      timeout_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      sd_q        <= sd_d;
      sd_en_q     <= sd_en_d;
      valid_q     <= valid_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      rd_cmd_q    <= rd_cmd_d;
      rd_done_q   <= rd_done_d;
      loaded_q    <= loaded_d;
      stat_busy_q <= stat_busy_d;
      timeout_q   <= timeout_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign spi_sd_o    = sd_q;
  assign spi_sd_en_o = sd_en_q;
  assign reg_valid_o = valid_q;
  assign reg_write_o = write_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_cheshire_spi_target.sv
// Directed bench for cheshire_spi_target: SPI host driver plus a
// reg-bus responder checking requests against a scoreboard queue.
module tb_cheshire_spi_target;
  import cheshire_spi_target_pkg::*;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_csb = 1'b1;
  logic spi_sdi = 1'b0;
  logic spi_sdo, spi_sd_en;

  cheshire_spi_target_if #(.AddrWidth(AW)) bus ();

  always #5 clk = ~clk;

  cheshire_spi_target #(
    .AddrWidth (AW),
    .SyncStages(2),
    .DummyBits (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .spi_sck_i  (spi_sck),
    .spi_csb_i  (spi_csb),
    .spi_sd_i   (spi_sdi),
    .spi_sd_o   (spi_sdo),
    .spi_sd_en_o(spi_sd_en),
    .reg_valid_o(bus.valid),
    .reg_write_o(bus.write),
    .reg_addr_o (bus.addr),
    .reg_wdata_o(bus.wdata),
    .reg_wstrb_o(bus.wstrb),
    .reg_ready_i(bus.ready),
    .reg_rdata_i(bus.rdata),
    .reg_error_i(bus.error)
  );

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  req_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_req = 0;
  int          resp_delay = 3;
  logic [31:0] resp_rdata = '0;
  logic        resp_error = 1'b0;
  logic        en_seen;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Host: sdi set while sck low, sdo sampled just before each rise.
  task automatic spi_frame(input logic [127:0] mosi, input int n,
                           input bit close, output logic [127:0] miso);
    miso = '0;
    en_seen = 1'b0;
    spi_csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi = mosi[i];
      repeat (4) @(negedge clk);
      miso[i] = spi_sdo;
      if (spi_sd_en) en_seen = 1'b1;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    spi_sdi = 1'b0;
    if (close) begin
      repeat (4) @(negedge clk);
      spi_csb = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp_v);
    logic [127:0] m;
    spi_frame({112'b0, SpiTgtCmdStatus, 8'h00}, 16, 1'b1, m);
    check(tag, m[7:0], exp_v);
  endtask

  // Bus responder: pops the expected request, answers after resp_delay.
  initial begin : bus_model
    req_t        r;
    logic [AW-1:0] a0;
    bus.ready = 1'b0;
    bus.rdata = '0;
    bus.error = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.valid) begin
        n_req++;
        check("req_expected", 64'(exp_q.size() > 0), 64'd1);
        r = '0;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        check("req_write", bus.write, r.write);
        check("req_addr", bus.addr, r.addr);
        check("req_wstrb", bus.wstrb, 4'hF);
        if (r.write) check("req_wdata", bus.wdata, r.wdata);
        a0 = bus.addr;
        repeat (resp_delay) @(negedge clk);
        check("req_held", {bus.valid, bus.addr}, {1'b1, a0});
        bus.ready = 1'b1;
        bus.rdata = resp_rdata;
        bus.error = resp_error;
        @(negedge clk);
        bus.ready = 1'b0;
        bus.error = 1'b0;
        check("req_drop", bus.valid, 1'b0);
      end
    end
  end

  initial begin : stim
    logic [127:0] m;
    int           nr;

    repeat (5) @(negedge clk);
    check("reset_outs",
          {bus.valid, bus.write, bus.addr, bus.wdata, bus.wstrb,
           spi_sdo, spi_sd_en},
          '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write
    resp_delay = 3;
    exp_q.push_back('{1'b1, 32'h0300_0010, 32'hCAFE_F00D});
    spi_frame({56'b0, SpiTgtCmdWrite, 32'h0300_0010, 32'hCAFE_F00D},
              72, 1'b1, m);
    check("wr_sd_en", en_seen, 1'b0);
    repeat (10) @(negedge clk);

    // Read
    resp_delay = 5;
    resp_rdata = 32'h1234_5678;
    exp_q.push_back('{1'b0, 32'h0300_0004, 32'h0});
    spi_frame({48'b0, SpiTgtCmdRead, 32'h0300_0004, 8'h00, 32'h0},
              80, 1'b1, m);
    check("rd_miso", m[31:0], 32'h1234_5678);
    check("rd_sd_en", en_seen, 1'b1);
    read_status("rd_status", 8'h00);

    // Timeout
    resp_delay = 600;
    resp_rdata = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b0, 32'h0300_0008, 32'h0});
    spi_frame({48'b0, SpiTgtCmdRead, 32'h0300_0008, 8'h00, 32'h0},
              80, 1'b1, m);
    check("tmo_miso", m[31:0], 32'hFFFF_FFFF);
    read_status("tmo_status_busy", 8'h06);
    for (int i = 0; i < 2000; i++) begin
      if (!bus.valid) break;
      @(negedge clk);
    end
    check("tmo_retired", bus.valid, 1'b0);
    repeat (4) @(negedge clk);
    read_status("tmo_status_done", 8'h02);
    read_status("tmo_status_clr", 8'h00);

    // Abort after 20 data bits, then a clean write
    resp_delay = 3;
    nr = n_req;
    spi_frame({68'b0, SpiTgtCmdWrite, 32'h0000_0020, 20'hABCDE},
              60, 1'b1, m);
    repeat (10) @(negedge clk);
    check("abort_no_req", nr, n_req);
    exp_q.push_back('{1'b1, 32'h0000_0010, 32'h0000_0001});
    spi_frame({56'b0, SpiTgtCmdWrite, 32'h0000_0010, 32'h0000_0001},
              72, 1'b1, m);
    repeat (10) @(negedge clk);
    check("abort_next_req", n_req, nr + 1);

    // Bus error read
    resp_delay = 5;
    resp_error = 1'b1;
    resp_rdata = 32'h5555_AAAA;
    exp_q.push_back('{1'b0, 32'h0300_000C, 32'h0});
    spi_frame({48'b0, SpiTgtCmdRead, 32'h0300_000C, 8'h00, 32'h0},
              80, 1'b1, m);
    resp_error = 1'b0;
    check("err_miso", m[31:0], 32'hFFFF_FFFF);
    read_status("err_status", 8'h01);

    // Illegal command
    nr = n_req;
    spi_frame({56'b0, 8'hA5, 64'hFFFF_0000_A5A5_5A5A}, 72, 1'b1, m);
    check("ill_sd_en", en_seen, 1'b0);
    check("ill_no_req", n_req, nr);

    // Reset mid-ADDR
    spi_frame({104'b0, SpiTgtCmdWrite, 16'hABCD}, 24, 1'b0, m);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outs",
          {bus.valid, bus.write, bus.addr, bus.wdata, bus.wstrb,
           spi_sdo, spi_sd_en},
          '0);
    spi_csb = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    read_status("rst_status", 8'h00);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
